// File: rtl/tag_ctrl2.sv
// Two-way set-associative tag lookup controller.
// Handles hit/miss resolution, victim choice, refill handshake and a flush of all valid bits.
module tag_ctrl2 #(
   parameter int SETS       = 256,
   parameter int INDEX_BITS = 8,
   parameter int TAG_BITS   = 20
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [INDEX_BITS-1:0] req_index,
   input  logic [TAG_BITS-1:0]   req_tag,
   output logic                  resp_valid,
   output logic                  resp_hit,
   output logic                  resp_way,
   output logic                  refill_valid,
   input  logic                  refill_ready,
   output logic [INDEX_BITS-1:0] refill_index,
   output logic [TAG_BITS-1:0]   refill_tag,
   output logic                  refill_way,
   input  logic                  flush,
   output logic [INDEX_BITS-1:0] line_selector,
   input  logic                  lru_way,
   output logic                  lru_update,
   output logic                  referenced_set
);

   // state     | meaning
   // ST_IDLE   | ready for a request; flush clears all valid bits here
   // ST_LOOKUP | compare captured tag against both ways, respond on hit
   // ST_REFILL | miss outstanding, hold refill request until refill_ready
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOOKUP = 2'd1,
      ST_REFILL = 2'd2
   } state_t;

   state_t                r_state;
   logic [INDEX_BITS-1:0] r_index;
   logic [TAG_BITS-1:0]   r_tag;
   logic                  r_victim;
   logic [SETS-1:0]       r_vld0;
   logic [SETS-1:0]       r_vld1;
   logic [TAG_BITS-1:0]   r_tmem0 [SETS];
   logic [TAG_BITS-1:0]   r_tmem1 [SETS];

   logic w_v0;
   logic w_v1;
   logic w_hit0;
   logic w_hit1;
   logic w_hit;
   logic w_victim;
   logic w_accept;
   logic w_fill;
   logic w_lookup_hit;

   assign w_v0         = r_vld0[r_index];
   assign w_v1         = r_vld1[r_index];
   assign w_hit0       = w_v0 && (r_tmem0[r_index] == r_tag);
   assign w_hit1       = w_v1 && (r_tmem1[r_index] == r_tag);
   assign w_hit        = w_hit0 || w_hit1;
   // Fill an empty way first; only consult the LRU table when the set is full.
   assign w_victim     = !w_v0 ? 1'b0 : (!w_v1 ? 1'b1 : lru_way);
   assign w_accept     = req_valid && req_ready;
   assign w_fill       = (r_state == ST_REFILL) && refill_ready;
   assign w_lookup_hit = (r_state == ST_LOOKUP) && w_hit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_index  <= '0;
         r_tag    <= '0;
         r_victim <= 1'b0;
         r_vld0   <= '0;
         r_vld1   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (flush) begin
                  r_vld0 <= '0;
                  r_vld1 <= '0;
               end else if (w_accept) begin
                  r_index <= req_index;
                  r_tag   <= req_tag;
                  r_state <= ST_LOOKUP;
               end
            end
            ST_LOOKUP: begin
               if (w_hit) begin
                  r_state <= ST_IDLE;
               end else begin
                  r_victim <= w_victim;
                  r_state  <= ST_REFILL;
               end
            end
            ST_REFILL: begin
               if (refill_ready) begin
                  if (r_victim) r_vld1[r_index] <= 1'b1;
                  else          r_vld0[r_index] <= 1'b1;
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Tag arrays carry no reset; the valid bits gate every hit.
   always_ff @(posedge clk) begin
      if (w_fill) begin
         if (r_victim) r_tmem1[r_index] <= r_tag;
         else          r_tmem0[r_index] <= r_tag;
      end
   end

   always_comb begin
      req_ready      = rst_n && (r_state == ST_IDLE) && !flush;
      resp_valid     = w_lookup_hit || w_fill;
      resp_hit       = w_lookup_hit;
      resp_way       = 1'b0;
      if (w_lookup_hit) resp_way = !w_hit0;
      else if (w_fill)  resp_way = r_victim;
      lru_update     = w_lookup_hit || w_fill;
      referenced_set = resp_way;
      refill_valid   = (r_state == ST_REFILL);
      refill_index   = r_index;
      refill_tag     = r_tag;
      refill_way     = r_victim;
      line_selector  = r_index;
   end

endmodule
